// File: rtl/robot_drive_pkg.sv
// Shared definitions for the two-motor drive controller.
//   drive_state_e : FSM state codes, also the value presented on state_o
//   dir_e         : H-bridge {in1,in2} codes per motor side
//   cmd_e         : one-hot command pulses collapsed to a single decoded command
//   pins_t        : direction code pair {left, right}
//   prio_cmd      : resolves simultaneous pulses, stop > back > fwd > left > right
//   cmd_state     : state a decoded command steers to
//   pins_of       : direction pins each state drives
package robot_drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FWD        = 3'd1,
    ST_BACK       = 3'd2,
    ST_LEFT       = 3'd3,
    ST_RIGHT      = 3'd4,
    ST_AVOID_BACK = 3'd5,
    ST_AVOID_TURN = 3'd6
  } drive_state_e;

  typedef enum logic [1:0] {
    DIR_COAST = 2'b00,
    DIR_BACK  = 2'b01,
    DIR_FWD   = 2'b10
  } dir_e;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_STOP, CMD_BACK, CMD_FWD, CMD_LEFT, CMD_RIGHT
  } cmd_e;

  typedef struct packed {
    logic [1:0] left;
    logic [1:0] right;
  } pins_t;

  function automatic cmd_e prio_cmd(input logic stop, input logic back, input logic fwd,
                                    input logic left, input logic right);
    if (stop)       prio_cmd = CMD_STOP;
    else if (back)  prio_cmd = CMD_BACK;
    else if (fwd)   prio_cmd = CMD_FWD;
    else if (left)  prio_cmd = CMD_LEFT;
    else if (right) prio_cmd = CMD_RIGHT;
    else            prio_cmd = CMD_NONE;
  endfunction

  function automatic drive_state_e cmd_state(input cmd_e cmd, input drive_state_e cur);
    case (cmd)
      CMD_STOP:  cmd_state = ST_IDLE;
      CMD_BACK:  cmd_state = ST_BACK;
      CMD_FWD:   cmd_state = ST_FWD;
      CMD_LEFT:  cmd_state = ST_LEFT;
      CMD_RIGHT: cmd_state = ST_RIGHT;
      default:   cmd_state = cur;
    endcase
  endfunction

  function automatic pins_t pins_of(input drive_state_e st);
    pins_of.left  = DIR_COAST;
    pins_of.right = DIR_COAST;
    case (st)
      ST_FWD: begin
        pins_of.left  = DIR_FWD;
        pins_of.right = DIR_FWD;
      end
      ST_BACK, ST_AVOID_BACK: begin
        pins_of.left  = DIR_BACK;
        pins_of.right = DIR_BACK;
      end
      ST_LEFT: begin
        pins_of.left  = DIR_BACK;
        pins_of.right = DIR_FWD;
      end
      ST_RIGHT, ST_AVOID_TURN: begin
        pins_of.left  = DIR_FWD;
        pins_of.right = DIR_BACK;
      end
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/drive_pwm_ramp.sv
// Duty ramp and PWM generator shared by both motor sides.
//   clk, rst_n  : clock, asynchronous active-low reset
//   target      : duty the ramp walks toward, RAMP_STEP LSBs every RAMP_CYC clocks
//   force_zero  : emergency stop, clears the duty (and the latched PWM duty) next cycle
//   pwm         : registered PWM, high while the period counter is below the latched duty
//   cur_duty    : duty currently applied by the ramp
module drive_pwm_ramp #(
  parameter int PWM_W     = 8,
  parameter int PWM_DIV   = 20,
  parameter int RAMP_CYC  = 50_000,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] target,
  input  logic             force_zero,
  output logic             pwm,
  output logic [PWM_W-1:0] cur_duty
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int RMP_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [RMP_W-1:0] ramp_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_lat;
  logic             pwm_step;
  logic             ramp_tick;
  logic             pwm_wrap;
  logic             pwm_p1;

  // One ramp step toward tgt; the signed difference lets it land exactly on
  // the target instead of overshooting or wrapping through 0 / full scale.
  function automatic logic [PWM_W-1:0] ramp_sat(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] tgt);
    logic signed [PWM_W+1:0] diff;
    logic signed [PWM_W+1:0] step;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    step = (PWM_W+2)'(RAMP_STEP);
    if (diff > step)       ramp_sat = cur + PWM_W'(RAMP_STEP);
    else if (diff < -step) ramp_sat = cur - PWM_W'(RAMP_STEP);
    else                   ramp_sat = tgt;
  endfunction

  assign pwm_step  = (div_cnt == DIV_W'(PWM_DIV - 1));
  assign ramp_tick = (ramp_cnt == RMP_W'(RAMP_CYC - 1));
  assign pwm_wrap  = pwm_step && (pwm_cnt == '1);

  // p0: prescalers, ramp and period counter; duty_lat only reloads at wrap so
  // a period never sees two different duties.
  // p1: registered PWM compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      ramp_cnt <= '0;
      pwm_cnt  <= '0;
      cur_duty <= '0;
      duty_lat <= '0;
      pwm_p1   <= 1'b0;
    end else begin
      div_cnt  <= pwm_step ? '0 : div_cnt + 1'b1;
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
      if (pwm_step) pwm_cnt <= pwm_cnt + 1'b1;
      if (force_zero) begin
        cur_duty <= '0;
        duty_lat <= '0;
        pwm_p1   <= 1'b0;
      end else begin
        if (ramp_tick) cur_duty <= ramp_sat(cur_duty, target);
        if (pwm_wrap)  duty_lat <= cur_duty;
        pwm_p1 <= (pwm_cnt < duty_lat);
      end
    end
  end

  assign pwm = pwm_p1;

endmodule

// File: rtl/robot_drive_ctrl.sv
// Drive controller for the two-motor chassis: command FSM, safe direction
// reversal and the autonomous obstacle-avoid sequence.
//   clk, rst_n                         : 50 MHz clock, asynchronous active-low reset
//   cmd_fwd/back/left/right/stop       : one-cycle IR command pulses
//   auto_en                            : level, avoid obstacles autonomously
//   hr_flag / hr_flag_short            : obstacle closer than 25 cm / 10 cm
//   f_in1_l/f_in2_l/f_in1_r/f_in2_r    : H-bridge direction pins
//   f_pwm_l/f_pwm_r                    : motor PWM, same duty both sides
//   move_en                            : registered, applied duty != 0
//   state_o                            : registered FSM state code
module robot_drive_ctrl
  import robot_drive_pkg::*;
#(
  parameter int PWM_W       = 8,
  parameter int PWM_DIV     = 20,
  parameter int RAMP_CYC    = 50_000,
  parameter int RAMP_STEP   = 4,
  parameter int DUTY_CRUISE = 200,
  parameter int DUTY_TURN   = 120,
  parameter int REVERSE_CYC = 25_000_000,
  parameter int TURN_CYC    = 20_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_fwd,
  input  logic       cmd_back,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_stop,
  input  logic       auto_en,
  input  logic       hr_flag,
  input  logic       hr_flag_short,
  output logic       f_in1_l,
  output logic       f_in2_l,
  output logic       f_in1_r,
  output logic       f_in2_r,
  output logic       f_pwm_l,
  output logic       f_pwm_r,
  output logic       move_en,
  output logic [2:0] state_o
);

  localparam int RC_W = (REVERSE_CYC > 1) ? $clog2(REVERSE_CYC) : 1;
  localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  drive_state_e     state, state_nxt;
  cmd_e             cmd;
  pins_t            pins, pins_want;
  logic             pending;
  logic             force_zero;
  logic [RC_W-1:0]  rev_cnt;
  logic [TC_W-1:0]  turn_cnt;
  logic [PWM_W-1:0] target;
  logic [PWM_W-1:0] cur_duty;
  logic             pwm;
  logic             move_en_q;

  assign cmd        = prio_cmd(cmd_stop, cmd_back, cmd_fwd, cmd_left, cmd_right);
  assign pins_want  = pins_of(state);
  // A direction change waits here until the motors have ramped to zero.
  assign pending    = (pins != pins_want);
  assign force_zero = (state == ST_FWD) && hr_flag_short;

  always_comb begin
    state_nxt = state;
    if (cmd == CMD_STOP) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_FWD: begin
          if (hr_flag_short)        state_nxt = auto_en ? ST_AVOID_BACK : ST_IDLE;
          else if (cmd != CMD_NONE) state_nxt = cmd_state(cmd, state);
        end
        ST_AVOID_BACK: if (rev_cnt == RC_W'(REVERSE_CYC - 1)) state_nxt = ST_AVOID_TURN;
        ST_AVOID_TURN: if (turn_cnt == TC_W'(TURN_CYC - 1))   state_nxt = ST_FWD;
        default:       if (cmd != CMD_NONE) state_nxt = cmd_state(cmd, state);
      endcase
    end
  end

  always_comb begin
    target = '0;
    if (!pending) begin
      case (state)
        ST_FWD:  target = hr_flag ? PWM_W'(DUTY_CRUISE >> 1) : PWM_W'(DUTY_CRUISE);
        ST_BACK: target = PWM_W'(DUTY_CRUISE);
        ST_LEFT, ST_RIGHT, ST_AVOID_BACK, ST_AVOID_TURN: target = PWM_W'(DUTY_TURN);
        default: target = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pins      <= '0;
      rev_cnt   <= '0;
      turn_cnt  <= '0;
      move_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pending && (cur_duty == '0)) pins <= pins_want;
      // Timers only count while staying in their state, so every entry starts at 0.
      rev_cnt  <= ((state == ST_AVOID_BACK) && (state_nxt == ST_AVOID_BACK)) ? rev_cnt + 1'b1 : '0;
      turn_cnt <= ((state == ST_AVOID_TURN) && (state_nxt == ST_AVOID_TURN)) ? turn_cnt + 1'b1 : '0;
      move_en_q <= (cur_duty != '0);
    end
  end

  drive_pwm_ramp #(
    .PWM_W    (PWM_W),
    .PWM_DIV  (PWM_DIV),
    .RAMP_CYC (RAMP_CYC),
    .RAMP_STEP(RAMP_STEP)
  ) u_pwm_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .target    (target),
    .force_zero(force_zero),
    .pwm       (pwm),
    .cur_duty  (cur_duty)
  );

  assign f_in1_l = pins.left[1];
  assign f_in2_l = pins.left[0];
  assign f_in1_r = pins.right[1];
  assign f_in2_r = pins.right[0];
  assign f_pwm_l = pwm;
  assign f_pwm_r = pwm;
  assign move_en = move_en_q;
  assign state_o = state;

endmodule

// File: tb/tb_robot_drive_ctrl.sv
module tb_robot_drive_ctrl;
  import robot_drive_pkg::*;

  localparam int PWM_W = 8, PWM_DIV = 1, RAMP_CYC = 4, RAMP_STEP = 4;
  localparam int DUTY_CRUISE = 200, DUTY_TURN = 120, REVERSE_CYC = 100, TURN_CYC = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_fwd = 1'b0, cmd_back = 1'b0, cmd_left = 1'b0, cmd_right = 1'b0, cmd_stop = 1'b0;
  logic auto_en = 1'b0, hr_flag = 1'b0, hr_flag_short = 1'b0;
  logic f_in1_l, f_in2_l, f_in1_r, f_in2_r, f_pwm_l, f_pwm_r, move_en;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_err = 0;
  int prev_pins = 0;

  always #5 clk = ~clk;

  robot_drive_ctrl #(
    .PWM_W(PWM_W), .PWM_DIV(PWM_DIV), .RAMP_CYC(RAMP_CYC), .RAMP_STEP(RAMP_STEP),
    .DUTY_CRUISE(DUTY_CRUISE), .DUTY_TURN(DUTY_TURN),
    .REVERSE_CYC(REVERSE_CYC), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_fwd(cmd_fwd), .cmd_back(cmd_back), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_stop(cmd_stop), .auto_en(auto_en), .hr_flag(hr_flag), .hr_flag_short(hr_flag_short),
    .f_in1_l(f_in1_l), .f_in2_l(f_in2_l), .f_in1_r(f_in1_r), .f_in2_r(f_in2_r),
    .f_pwm_l(f_pwm_l), .f_pwm_r(f_pwm_r), .move_en(move_en), .state_o(state_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pins_now();
    return int'({f_in1_l, f_in2_l, f_in1_r, f_in2_r});
  endfunction

  // Reference model: pins and settled duty per state, command priority.
  function automatic int exp_pins(input int st);
    case (st)
      int'(ST_FWD):                         return 'b1010;
      int'(ST_BACK), int'(ST_AVOID_BACK):   return 'b0101;
      int'(ST_LEFT):                        return 'b0110;
      int'(ST_RIGHT), int'(ST_AVOID_TURN):  return 'b1001;
      default:                              return 'b0000;
    endcase
  endfunction

  function automatic int exp_duty(input int st, input bit hr);
    if (st == int'(ST_IDLE)) return 0;
    if (st == int'(ST_FWD))  return hr ? DUTY_CRUISE / 2 : DUTY_CRUISE;
    if (st == int'(ST_BACK)) return DUTY_CRUISE;
    return DUTY_TURN;
  endfunction

  // bits = {stop, back, fwd, left, right}
  function automatic int model_next(input int st, input logic [4:0] bits);
    if (bits[4]) return int'(ST_IDLE);
    if (bits[3]) return int'(ST_BACK);
    if (bits[2]) return int'(ST_FWD);
    if (bits[1]) return int'(ST_LEFT);
    if (bits[0]) return int'(ST_RIGHT);
    return st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [4:0] bits);
    {cmd_stop, cmd_back, cmd_fwd, cmd_left, cmd_right} = bits;
    tick();
    {cmd_stop, cmd_back, cmd_fwd, cmd_left, cmd_right} = 5'b0;
  endtask

  // High cycles over one full PWM period equal the duty once it is steady.
  task automatic check_duty(input string tag, input int exp);
    int hl, hrr;
    hl = 0;
    hrr = 0;
    repeat (256) begin
      tick();
      hl  += int'(f_pwm_l);
      hrr += int'(f_pwm_r);
    end
    chk({tag, "_pwm_l"}, hl, exp);
    chk({tag, "_pwm_r"}, hrr, exp);
  endtask

  // Pins may only change once the applied duty has reached zero.
  always @(posedge clk) begin
    #2;
    if (rst_n && (pins_now() != prev_pins)) chk("pins_change_move_en", int'(move_en), 0);
    prev_pins = pins_now();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol, m_state;
    logic me;
    logic [4:0] bits;
    bit hr;

    // 1: reset, forward from standstill
    wait_cyc(3);
    chk("rst_state", int'(state_o), int'(ST_IDLE));
    chk("rst_pins", pins_now(), 0);
    chk("rst_pwm", int'(f_pwm_l | f_pwm_r), 0);
    chk("rst_move_en", int'(move_en), 0);
    rst_n = 1'b1;
    tick();
    pulse(5'b00100);
    chk("t1_state", int'(state_o), int'(ST_FWD));
    tick();
    chk("t1_pins", pins_now(), 'b1010);
    wait_cyc(500);
    chk("t1_move_en", int'(move_en), 1);
    check_duty("t1", DUTY_CRUISE);

    // 2: reversal holds pins until the ramp reaches zero
    pulse(5'b01000);
    chk("t2_state", int'(state_o), int'(ST_BACK));
    n = 0;
    viol = 0;
    while (pins_now() != 'b0101 && n < 1000) begin
      if (pins_now() != 'b1010) viol++;
      tick();
      n++;
    end
    chk("t2_pins", pins_now(), 'b0101);
    chk("t2_held_viol", viol, 0);
    chk("t2_hold_window", int'(n >= 190 && n <= 215), 1);
    wait_cyc(500);
    check_duty("t2", DUTY_CRUISE);

    // 3: hr_flag halves cruise duty in FWD
    pulse(5'b00100);
    wait_cyc(750);
    chk("t3_pins", pins_now(), 'b1010);
    check_duty("t3_full", DUTY_CRUISE);
    hr_flag = 1'b1;
    wait_cyc(400);
    check_duty("t3_half", DUTY_CRUISE / 2);
    hr_flag = 1'b0;
    wait_cyc(400);
    check_duty("t3_back", DUTY_CRUISE);

    // 4: autonomous avoid sequence
    auto_en = 1'b1;
    hr_flag_short = 1'b1;
    tick();
    hr_flag_short = 1'b0;
    chk("t4_state_ab", int'(state_o), int'(ST_AVOID_BACK));
    chk("t4_pwm_zero", int'(f_pwm_l | f_pwm_r), 0);
    n = 0;
    me = 1'b1;
    while (state_o == ST_AVOID_BACK && n < 1000) begin
      n++;
      tick();
      if (n == 1) me = move_en;
    end
    chk("t4_duty_zero", int'(me), 0);
    chk("t4_ab_len", n, REVERSE_CYC);
    chk("t4_state_at", int'(state_o), int'(ST_AVOID_TURN));
    n = 0;
    while (state_o == ST_AVOID_TURN && n < 1000) begin
      n++;
      tick();
    end
    chk("t4_at_len", n, TURN_CYC);
    chk("t4_state_fwd", int'(state_o), int'(ST_FWD));
    wait_cyc(600);
    chk("t4_pins_fwd", pins_now(), 'b1010);

    // 5: close obstacle without auto mode stops
    auto_en = 1'b0;
    hr_flag_short = 1'b1;
    tick();
    hr_flag_short = 1'b0;
    chk("t5_state", int'(state_o), int'(ST_IDLE));
    chk("t5_pwm", int'(f_pwm_l | f_pwm_r), 0);
    tick();
    chk("t5_move_en", int'(move_en), 0);
    tick();
    chk("t5_pins", pins_now(), 0);

    // 6: stop priority, abort avoid, async reset mid-ramp
    pulse(5'b00100);
    wait_cyc(20);
    pulse(5'b10100);
    chk("t6_stop_prio", int'(state_o), int'(ST_IDLE));
    pulse(5'b00100);
    wait_cyc(10);
    auto_en = 1'b1;
    hr_flag_short = 1'b1;
    tick();
    hr_flag_short = 1'b0;
    wait_cyc(20);
    chk("t6_in_ab", int'(state_o), int'(ST_AVOID_BACK));
    pulse(5'b01100);
    chk("t6_ab_ignores_cmd", int'(state_o), int'(ST_AVOID_BACK));
    pulse(5'b10000);
    chk("t6_ab_stop", int'(state_o), int'(ST_IDLE));
    auto_en = 1'b0;
    pulse(5'b00100);
    wait_cyc(150);
    chk("t6_moving", int'(move_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", int'(state_o), 0);
    chk("t6_rst_pins", pins_now(), 0);
    chk("t6_rst_pwm", int'(f_pwm_l | f_pwm_r), 0);
    chk("t6_rst_move_en", int'(move_en), 0);
    wait_cyc(2);
    rst_n = 1'b1;
    tick();

    // Random command sequences against the model
    m_state = int'(ST_IDLE);
    for (int i = 0; i < 12; i++) begin
      bits = 5'($urandom_range(0, 31));
      hr = 1'($urandom_range(0, 1));
      hr_flag = hr;
      pulse(bits);
      m_state = model_next(m_state, bits);
      wait_cyc(700);
      chk("rnd_state", int'(state_o), m_state);
      chk("rnd_pins", pins_now(), exp_pins(m_state));
      check_duty("rnd", exp_duty(m_state, hr));
    end
    hr_flag = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
